seq_mult_8: RTL and testbench

Sequential 8x8 shift-and-add multiplier that sits directly downstream of the 8-bit carry-select adder. It uses one instance of that adder as its only arithmetic element and produces one 16-bit product every 10 cycles. Operands arrive on a valid/ready handshake and results leave on one. It is the datapath stage that turns the adder into a multiply unit for the lab ALU.

---
 rtl/seq_mult_pkg.sv | 22 ++
 rtl/seq_mult_8_if.sv | 27 ++
 rtl/csa_8.sv | 24 ++
 rtl/seq_mult_8.sv | 126 ++++++++++++
 tb/tb_seq_mult_8.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_mult_pkg.sv
// Shared constants, FSM encoding and magnitude helper for the 8x8 sequential multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_mult_pkg;

    localparam int OPW  = 8;
    localparam int PW   = 16;
    localparam int CNTW = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_NEG  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's complement magnitude; 8'h80 maps to 8'h80, read as unsigned 128.
    function automatic logic [OPW-1:0] mag(input logic [OPW-1:0] v);
        return v[OPW-1] ? (~v + OPW'(1)) : v;
    endfunction

endpackage

// File: rtl/seq_mult_8_if.sv
// Operand/result handshake bundle for seq_mult_8.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carried here; the multiplier owns the responses.
interface seq_mult_8_if;
    import seq_mult_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [OPW-1:0]  a;
    logic [OPW-1:0]  b;
    logic            sgn;
    logic            out_valid;
    logic            out_ready;
    logic [PW-1:0]   product;
    logic            busy;

    modport master (
        output in_valid, a, b, sgn, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, sgn, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/csa_8.sv
// 8-bit carry-select adder: ripple low nibble, upper nibble precomputed for both carries.
// Latency: combinational.
// Backpressure: none.
module csa_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [4:0] lo_s;
    logic [4:0] hi_c0;
    logic [4:0] hi_c1;

    assign lo_s  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
    assign hi_c0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    assign hi_c1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

    // The low-nibble carry selects which precomputed upper half is used.
    assign sum  = {(lo_s[4] ? hi_c1[3:0] : hi_c0[3:0]), lo_s[3:0]};
    assign cout = lo_s[4] ? hi_c1[4] : hi_c0[4];

endmodule

// File: rtl/seq_mult_8.sv
// Shift-and-add 8x8->16 multiplier around one csa_8; SEQ_MULT_SIGNED_EN adds two's complement via a NEG step.
// Latency: 9 cycles accept-to-out_valid (10 with SEQ_MULT_SIGNED_EN); one operation in flight at a time.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module seq_mult_8
    import seq_mult_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    seq_mult_8_if.slave  bus
);

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [OPW-1:0]    mcand_q, mcand_d;
    logic [PW:0]       acc_q, acc_d;       // {carry, hi, lo}
    logic [OPW-1:0]    add_b;
    logic [OPW-1:0]    add_s;
    logic              add_c;
    logic [OPW-1:0]    load_mcand;
    logic [OPW-1:0]    load_lo;

`ifdef SEQ_MULT_SIGNED_EN
    logic              neg_q, neg_d;
    logic              load_neg;

    assign load_mcand = bus.sgn ? mag(bus.a) : bus.a;
    assign load_lo    = bus.sgn ? mag(bus.b) : bus.b;
    assign load_neg   = bus.sgn & (bus.a[OPW-1] ^ bus.b[OPW-1]);
`else
    logic              unused_sgn;

    assign unused_sgn = bus.sgn;
    assign load_mcand = bus.a;
    assign load_lo    = bus.b;
`endif

    // The only arithmetic in the loop: hi plus the gated multiplicand, no carry in.
    assign add_b = acc_q[0] ? mcand_q : '0;

    csa_8 u_csa (
        .a    (acc_q[PW-1:OPW]),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_s),
        .cout (add_c)
    );

    // Next-state and datapath update for the control FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
`ifdef SEQ_MULT_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                    mcand_d = load_mcand;
                    acc_d   = {{(PW + 1 - OPW){1'b0}}, load_lo};
`ifdef SEQ_MULT_SIGNED_EN
                    neg_d   = load_neg;
`endif
                end
            end
            ST_CALC: begin
                // {0, c, s, lo} >> 1: the adder carry lands in bit 15, bit 16 clears.
                acc_d = {1'b0, add_c, add_s, acc_q[OPW-1:1]};
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(OPW - 1)) begin
`ifdef SEQ_MULT_SIGNED_EN
                    state_d = ST_NEG;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef SEQ_MULT_SIGNED_EN
            ST_NEG: begin
                if (neg_q) begin
                    acc_d[PW-1:0] = ~acc_q[PW-1:0] + PW'(1);
                end
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.product   = acc_q[PW-1:0];

endmodule

// File: tb/tb_seq_mult_8.sv
// Self-checking bench for seq_mult_8: directed cases plus randomized traffic against a latency/arithmetic model.
// Latency: model expects 9 cycles (10 with SEQ_MULT_SIGNED_EN) accept-to-valid.
// Backpressure: out_ready driven both held-low and randomly; in_valid pulsed while busy.
module tb_seq_mult_8;

`ifdef SEQ_MULT_SIGNED_EN
    localparam int LAT    = 10;
    localparam bit SIGNED = 1'b1;
`else
    localparam int LAT    = 9;
    localparam bit SIGNED = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_mult_8_if bus ();

    seq_mult_8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference product straight from integer arithmetic.
    function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y, input logic s);
        int px;
        int py;
        int r;
        px = int'(x);
        py = int'(y);
        if (s && SIGNED) begin
            px = int'($signed(x));
            py = int'($signed(y));
        end
        r = px * py;
        return r[15:0];
    endfunction

    // Model: one job at a time, result valid LAT-1 edges after the accept edge, held until taken.
    logic        m_busy = 1'b0;
    int          m_wait = 0;
    logic [15:0] m_prod = 16'h0;
    int          m_done = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_wait <= 0;
            m_prod <= 16'h0;
        end else if (m_busy && m_wait == 0) begin
            if (bus.out_ready) begin
                m_busy <= 1'b0;
                m_done <= m_done + 1;
            end
        end else if (m_busy) begin
            m_wait <= m_wait - 1;
        end else if (bus.in_valid) begin
            m_busy <= 1'b1;
            m_wait <= LAT - 1;
            m_prod <= ref_prod(bus.a, bus.b, bus.sgn);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic exp_v;
        exp_v = m_busy && (m_wait == 0);
        check("in_ready", 32'(bus.in_ready), 32'(!m_busy));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("out_valid", 32'(bus.out_valid), 32'(exp_v));
        if (exp_v) check("product", 32'(bus.product), 32'(m_prod));
    end

    // Presents an operand pair from a negedge and returns the cycle stamp before the accept edge.
    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic s, input bit keep,
                        output int t_acc);
        bus.a = x;
        bus.b = y;
        bus.sgn = s;
        bus.in_valid = 1'b1;
        t_acc = -1;
        for (int i = 0; i < 60; i++) begin
            if (bus.in_ready) begin
                t_acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t_acc < 0) check("send timeout", 32'd1, 32'd0);
        @(negedge clk);
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int t_v);
        t_v = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) begin
                t_v = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t_v < 0) check("out_valid timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_ready(output int t_r);
        t_r = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.in_ready) begin
                t_r = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t_r < 0) check("in_ready timeout", 32'd1, 32'd0);
    endtask

    // Runs one operation with out_ready high and pins latency and product to literals.
    task automatic directed(input string nm, input logic [7:0] x, input logic [7:0] y,
                            input logic s, input logic [15:0] lit);
        int ta;
        int tv;
        bus.out_ready = 1'b1;
        send(x, y, s, 1'b0, ta);
        wait_valid(tv);
        check({nm, " latency"}, 32'(tv - ta), 32'(LAT));
        check({nm, " product"}, 32'(bus.product), 32'(lit));
        check({nm, " model"}, 32'(m_prod), 32'(lit));
        @(negedge clk);
        check({nm, " in_ready after"}, 32'(bus.in_ready), 32'd1);
    endtask

    logic [7:0] corner [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

    initial begin
        int t1;
        int t2;
        int tv;
        int d0;
        bus.in_valid  = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.sgn       = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset product", 32'(bus.product), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        directed("13x11", 8'd13, 8'd11, 1'b0, 16'h008F);
        directed("FFxFF", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        directed("FDx05 unsigned", 8'hFD, 8'h05, 1'b0, 16'h04F1);
        directed("FDx05 sgn", 8'hFD, 8'h05, 1'b1, SIGNED ? 16'hFFF1 : 16'h04F1);

        // Result held with out_ready low; in_valid pulses must be ignored.
        bus.out_ready = 1'b0;
        send(8'h00, 8'h5A, 1'b0, 1'b0, t1);
        wait_valid(tv);
        for (int i = 0; i < 20; i++) begin
            check("hold out_valid", 32'(bus.out_valid), 32'd1);
            check("hold product", 32'(bus.product), 32'h0);
            check("hold in_ready", 32'(bus.in_ready), 32'd0);
            bus.in_valid = i[0];
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release out_valid", 32'(bus.out_valid), 32'd0);
        check("release in_ready", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset in the middle of CALC (cnt = 4).
        send(8'hAA, 8'h55, 1'b0, 1'b0, t1);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst in_ready", 32'(bus.in_ready), 32'd1);
        check("arst out_valid", 32'(bus.out_valid), 32'd0);
        check("arst busy", 32'(bus.busy), 32'd0);
        check("arst product", 32'(bus.product), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        directed("03x07", 8'h03, 8'h07, 1'b0, 16'h0015);

        // Back-to-back with in_valid held high.
        bus.out_ready = 1'b1;
        send(8'd2, 8'd3, 1'b0, 1'b1, t1);
        bus.a = 8'd4;
        bus.b = 8'd5;
        wait_valid(tv);
        check("b2b first product", 32'(bus.product), 32'h0006);
        @(negedge clk);
        wait_ready(t2);
        check("b2b spacing", 32'(t2 - t1), 32'(LAT + 1));
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(tv);
        check("b2b second product", 32'(bus.product), 32'h0014);
        @(negedge clk);

`ifdef SEQ_MULT_SIGNED_EN
        directed("-128x-128", 8'h80, 8'h80, 1'b1, 16'h4000);
        directed("-1x-1", 8'hFF, 8'hFF, 1'b1, 16'h0001);
        directed("-128x1", 8'h80, 8'h01, 1'b1, 16'hFF80);
`endif

        // Random traffic with random backpressure and one reset pulse.
        d0 = m_done;
        for (int i = 0; i < 1500; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.a         = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 8'($urandom);
            bus.b         = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 8'($urandom);
            bus.sgn       = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst_n         = (i != 700);
            @(negedge clk);
        end
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (15) @(negedge clk);
        check("random ops completed", 32'((m_done - d0) > 30), 32'd1);
        check("idle at end", 32'(bus.in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
